booth_mult_seq: RTL and testbench

- Sequential radix-2 Booth multiplier controller for the arithmetic unit.
- Owns the A/Q/Q-1 shift registers and the iteration counter.
- Drives one cla_8bit instance as its only add/subtract datapath.
- Takes two signed 8-bit operands on a start pulse and returns a signed 16-bit product after a fixed 9-cycle latency, with a busy/done handshake toward the ALU top level.

---
 rtl/booth_pkg.sv | 9 +
 rtl/cla_8bit.sv | 21 ++
 rtl/booth_mult_seq.sv | 120 ++++++++++++
 tb/tb_booth_mult_seq.sv | 146 ++++++++++++++
 4 files changed

// File: rtl/booth_pkg.sv
// Shared types and constants for the sequential radix-2 Booth multiplier.
package booth_pkg;
   localparam int WIDTH = 8;
   localparam int CNT_W = 3;
   localparam logic [CNT_W-1:0] LAST_ITER = 3'd7;

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;
   typedef enum logic [1:0] {OP_NOP, OP_ADD, OP_SUB} booth_op_e;
endpackage

// File: rtl/cla_8bit.sv
// 8-bit carry-lookahead adder, purely combinational.
module cla_8bit (
   input  logic [7:0] a,
   input  logic [7:0] b,
   input  logic       cin,
   output logic [7:0] sum,
   output logic       cout
);
   logic [7:0] g, p;
   logic [8:0] c;

   always_comb begin
      g = a & b;
      p = a ^ b;
      c = '0;
      c[0] = cin;
      for (int i = 0; i < 8; i++) c[i+1] = g[i] | (p[i] & c[i]);
      sum  = p ^ c[7:0];
      cout = c[8];
   end
endmodule

// File: rtl/booth_mult_seq.sv
// Sequential radix-2 Booth multiplier: one iteration per cycle through a
// single cla_8bit, busy/done handshake, product register held between runs.
module booth_mult_seq #(
   parameter int WIDTH = booth_pkg::WIDTH,
   parameter int CNT_W = booth_pkg::CNT_W
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic [WIDTH-1:0]   multiplicand,
   input  logic [WIDTH-1:0]   multiplier,
   output logic               busy,
   output logic               done,
   output logic [2*WIDTH-1:0] product
);
   import booth_pkg::*;

   generate
      if (WIDTH != 8 || CNT_W != 3) begin : g_bad_width
         $error("booth_mult_seq supports only WIDTH=8 / CNT_W=3 (cla_8bit datapath)");
      end
   endgenerate

   state_e             state_q, state_d;
   logic [WIDTH-1:0]   a_q, a_d, q_q, q_d, m_q, m_d;
   logic               q1_q, q1_d, done_q, done_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [2*WIDTH-1:0] product_q, product_d;

   booth_op_e          op;
   logic [WIDTH-1:0]   bop, sum, res;
   logic               cin, cout, s;

   always_comb begin
      case ({q_q[0], q1_q})
         2'b01:   op = OP_ADD;
         2'b10:   op = OP_SUB;
         default: op = OP_NOP;
      endcase
      bop = (op == OP_SUB) ? ~m_q : (op == OP_ADD) ? m_q : '0;
      cin = (op == OP_SUB);
   end

   cla_8bit u_cla (
      .a    (a_q),
      .b    (bop),
      .cin  (cin),
      .sum  (sum),
      .cout (cout)
   );

   // s is the true 9th sum bit, so M = -128 subtracts without overflow.
   always_comb begin
      res = (op == OP_NOP) ? a_q : sum;
      s   = (op == OP_NOP) ? a_q[WIDTH-1] : (a_q[WIDTH-1] ^ bop[WIDTH-1] ^ cout);
   end

   always_comb begin
      state_d   = state_q;
      a_d       = a_q;
      q_d       = q_q;
      m_d       = m_q;
      q1_d      = q1_q;
      cnt_d     = cnt_q;
      product_d = product_q;
      case (state_q)
         // DONE also accepts start so back-to-back runs land every 9 cycles.
         IDLE, DONE: begin
            if (start) begin
               a_d     = '0;
               q_d     = multiplier;
               m_d     = multiplicand;
               q1_d    = 1'b0;
               cnt_d   = '0;
               state_d = RUN;
            end else begin
               state_d = IDLE;
            end
         end
         RUN: begin
            a_d   = {s, res[WIDTH-1:1]};
            q_d   = {res[0], q_q[WIDTH-1:1]};
            q1_d  = q_q[0];
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == LAST_ITER) begin
               state_d   = DONE;
               product_d = {a_d, q_d};
            end
         end
         default: state_d = IDLE;
      endcase
      done_d = (state_d == DONE);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= IDLE;
         a_q       <= '0;
         q_q       <= '0;
         m_q       <= '0;
         q1_q      <= 1'b0;
         cnt_q     <= '0;
         product_q <= '0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         a_q       <= a_d;
         q_q       <= q_d;
         m_q       <= m_d;
         q1_q      <= q1_d;
         cnt_q     <= cnt_d;
         product_q <= product_d;
         done_q    <= done_d;
      end
   end

   assign busy    = (state_q != IDLE);
   assign done    = done_q;
   assign product = product_q;
endmodule

// File: tb/tb_booth_mult_seq.sv
// Self-checking bench for booth_mult_seq: directed table, handshake,
// mid-run reset and random pairs against a plain-arithmetic model.
module tb_booth_mult_seq;
   logic        clk = 1'b0;
   logic        rst, start;
   logic [7:0]  multiplicand, multiplier;
   logic        busy, done;
   logic [15:0] product;

   int checks = 0;
   int errors = 0;

   booth_mult_seq dut (
      .clk          (clk),
      .rst          (rst),
      .start        (start),
      .multiplicand (multiplicand),
      .multiplier   (multiplier),
      .busy         (busy),
      .done         (done),
      .product      (product)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [7:0]  m;
      logic [7:0]  q;
      logic [15:0] exp;
   } vec_t;

   function automatic logic [15:0] ref_mult(input logic [7:0] m, input logic [7:0] q);
      int r;
      r = int'($signed(m)) * int'($signed(q));
      return r[15:0];
   endfunction

   task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%04h expected 0x%04h", name, act, exp);
      end
   endtask

   // One full transaction from IDLE or DONE; operands are scrambled after E0.
   task automatic do_mult(input logic [7:0] m, input logic [7:0] q,
                          input logic [15:0] exp, input string tag);
      int n;
      @(negedge clk);
      start = 1'b1; multiplicand = m; multiplier = q;
      @(posedge clk); #1;
      start = 1'b0; multiplicand = 8'($urandom); multiplier = 8'($urandom);
      chk({tag, " busy_after_start"}, 16'(busy), 16'd1);
      n = 0;
      while (done !== 1'b1 && n < 20) begin
         @(posedge clk); #1;
         n++;
      end
      chk({tag, " latency"}, 16'(n), 16'd8);
      chk({tag, " busy_at_done"}, 16'(busy), 16'd1);
      chk({tag, " product"}, product, exp);
   endtask

   vec_t        vecs[7];
   logic [15:0] expq[$];
   logic [15:0] last_p, e;
   logic [7:0]  rm, rq;
   int          done_cnt, stray;

   initial begin
      vecs[0] = '{8'd3,    8'hFB, 16'hFFF1};
      vecs[1] = '{8'h80,   8'h80, 16'h4000};
      vecs[2] = '{8'h80,   8'h7F, 16'hC080};
      vecs[3] = '{8'h7F,   8'h7F, 16'h3F01};
      vecs[4] = '{8'h00,   8'h5A, 16'h0000};
      vecs[5] = '{8'h5A,   8'h01, 16'h005A};
      vecs[6] = '{8'hFF,   8'hFF, 16'h0001};

      rst = 1'b1; start = 1'b0; multiplicand = '0; multiplier = '0;
      #12;
      chk("reset busy", 16'(busy), 16'd0);
      chk("reset done", 16'(done), 16'd0);
      chk("reset product", product, 16'h0000);
      @(negedge clk); rst = 1'b0;

      for (int i = 0; i < 7; i++)
         do_mult(vecs[i].m, vecs[i].q, vecs[i].exp, $sformatf("vec%0d", i));

      // After a lone run, the machine returns to idle one cycle past done.
      @(posedge clk); #1;
      chk("idle done", 16'(done), 16'd0);
      chk("idle busy", 16'(busy), 16'd0);
      chk("idle product hold", product, 16'h0001);

      // start held high with fresh operands each cycle: accepts at 0, 9, 18.
      done_cnt = 0;
      last_p = product;
      for (int cyc = 0; cyc < 28; cyc++) begin
         @(negedge clk);
         rm = 8'($urandom); rq = 8'($urandom);
         start = 1'b1; multiplicand = rm; multiplier = rq;
         if (cyc % 9 == 0 && cyc < 27) expq.push_back(ref_mult(rm, rq));
         @(posedge clk); #1;
         chk($sformatf("hs done c%0d", cyc), 16'(done), 16'((cyc % 9) == 8));
         if (done === 1'b1) begin
            done_cnt++;
            e = (expq.size() > 0) ? expq.pop_front() : 16'hxxxx;
            chk($sformatf("hs product c%0d", cyc), product, e);
            last_p = product;
         end else begin
            chk($sformatf("hs hold c%0d", cyc), product, last_p);
         end
      end
      start = 1'b0;
      chk("hs done count", 16'(done_cnt), 16'd3);
      repeat (2) @(posedge clk);

      // Asynchronous reset mid-run discards the operation.
      @(negedge clk);
      start = 1'b1; multiplicand = 8'd7; multiplier = 8'd9;
      @(posedge clk); #1; start = 1'b0;
      repeat (4) @(posedge clk);
      #2 rst = 1'b1;
      #1;
      chk("midrst busy", 16'(busy), 16'd0);
      chk("midrst done", 16'(done), 16'd0);
      chk("midrst product", product, 16'h0000);
      #1 rst = 1'b0;
      stray = 0;
      repeat (12) begin
         @(posedge clk); #1;
         if (done === 1'b1) stray++;
      end
      chk("midrst no done", 16'(stray), 16'd0);
      do_mult(8'hE7, 8'h13, 16'hFE25, "post_rst");

      for (int i = 0; i < 1500; i++) begin
         rm = 8'($urandom); rq = 8'($urandom);
         do_mult(rm, rq, ref_mult(rm, rq), $sformatf("rnd%0d", i));
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
